// File: rtl/nand_prog_sequencer.sv
// nand_prog_sequencer
//   Turns one "program page" request into the SPI NAND command chain
//   WRITE_ENABLE -> PROG_LOAD1 -> PROG_EXEC -> GET_FEATURE(C0h) polling,
//   after waiting for the save FIFO to hold the requested byte count.
//   Reports pass/fail and the final status byte.
//
// Ports
//   CLK1, rst_n          clock (posedge) / async active-low reset
//   i_Start              one-cycle request, sampled only in IDLE
//   i_Row_Addr/Col_Addr  row for PROG_EXEC, column for PROG_LOAD1
//   i_Byte_Count         bytes the save FIFO must hold before loading
//   i_Fifo_Count         current save FIFO fill from mem_command
//   o_Command/o_CM_DV/o_Addr_Data   command handshake to mem_command
//   i_CM_Ready           controller ready
//   i_RX_Feature_Byte/DV feature byte returned by the controller
//   o_Busy/o_Done        activity flag / one-cycle completion pulse
//   o_Error              00 ok, 01 P_FAIL, 10 poll timeout, 11 fill timeout
//   o_Status             last status byte captured

package nand_cmd_pkg;
  // Encodings must track mem_command's command table.
  typedef enum logic [3:0] {
    RESET         = 4'd0,
    GET_FEATURE   = 4'd1,
    SET_FEATURE   = 4'd2,
    WRITE_ENABLE  = 4'd3,
    WRITE_DISABLE = 4'd4,
    PROG_LOAD1    = 4'd5,
    PROG_LOAD2    = 4'd6,
    PROG_EXEC     = 4'd7,
    PAGE_READ     = 4'd8,
    READ_CACHE    = 4'd9
  } SPI_Command;
endpackage

module nand_prog_sequencer
  import nand_cmd_pkg::*;
#(
  parameter int unsigned MAX_POLLS    = 1000,
  parameter int unsigned POLL_GAP     = 16,
  parameter int unsigned FILL_TIMEOUT = 65535
) (
  input  logic        CLK1,
  input  logic        rst_n,
  input  logic        i_Start,
  input  logic [23:0] i_Row_Addr,
  input  logic [12:0] i_Col_Addr,
  input  logic [11:0] i_Byte_Count,
  input  logic [11:0] i_Fifo_Count,
  output SPI_Command  o_Command,
  output logic        o_CM_DV,
  output logic [23:0] o_Addr_Data,
  input  logic        i_CM_Ready,
  input  logic [7:0]  i_RX_Feature_Byte,
  input  logic        i_RX_Feature_DV,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [1:0]  o_Error,
  output logic [7:0]  o_Status
);

  localparam int unsigned PCW = $clog2(MAX_POLLS + 1);
  localparam int unsigned GCW = $clog2(POLL_GAP + 1);
  localparam logic [PCW-1:0] POLL_LIMIT = PCW'(MAX_POLLS);
  localparam logic [GCW-1:0] GAP_LAST   = GCW'(POLL_GAP - 1);
  localparam logic [15:0]    FILL_LIMIT = 16'(FILL_TIMEOUT);
  localparam logic [7:0]     STATUS_REG = 8'hC0;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WREN, S_LOAD, S_EXEC, S_POLL, S_GAP, S_DONE
  } state_t;

  typedef enum logic [1:0] {PH_ISSUE, PH_ACK, PH_CMPL} phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [23:0] row_q, row_d;
  logic [12:0] col_q, col_d;
  logic [11:0] bcnt_q, bcnt_d;
  logic [15:0] fill_cnt_q, fill_cnt_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d, poll_next;
  logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
  logic        seen_q, seen_d;
  SPI_Command  cmd_q, cmd_d, cmd_sel;
  logic [23:0] addr_q, addr_d, addr_sel;
  logic        dv_q, dv_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  status_q, status_d;

  assign poll_next = poll_cnt_q + 1'b1;

  // Command word belonging to the current command state.
  always_comb begin
    cmd_sel  = WRITE_ENABLE;
    addr_sel = '0;
    case (state_q)
      S_LOAD: begin cmd_sel = PROG_LOAD1;  addr_sel = {11'd0, col_q};          end
      S_EXEC: begin cmd_sel = PROG_EXEC;   addr_sel = row_q;                   end
      S_POLL: begin cmd_sel = GET_FEATURE; addr_sel = {8'h00, STATUS_REG, 8'h00}; end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    row_d      = row_q;
    col_d      = col_q;
    bcnt_d     = bcnt_q;
    fill_cnt_d = fill_cnt_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    seen_d     = seen_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    dv_d       = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    status_d   = status_q;

    case (state_q)
      S_IDLE: begin
        // Drops busy the cycle after the done pulse.
        busy_d = 1'b0;
        if (i_Start) begin
          row_d      = i_Row_Addr;
          col_d      = i_Col_Addr;
          bcnt_d     = i_Byte_Count;
          err_d      = '0;
          status_d   = '0;
          fill_cnt_d = '0;
          poll_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = S_FILL;
        end
      end

      S_FILL: begin
        if (i_Fifo_Count >= bcnt_q) begin
          state_d = S_WREN;
          phase_d = PH_ISSUE;
        end else if (fill_cnt_q == FILL_LIMIT) begin
          err_d   = 2'b11;
          state_d = S_DONE;
        end else begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end

      S_WREN, S_LOAD, S_EXEC, S_POLL: begin
        // status_d/seen_d already include a DV arriving on the CMPL cycle.
        if (state_q == S_POLL && i_RX_Feature_DV) begin
          status_d = i_RX_Feature_Byte;
          seen_d   = 1'b1;
        end
        case (phase_q)
          PH_ISSUE: if (i_CM_Ready) begin
            cmd_d   = cmd_sel;
            addr_d  = addr_sel;
            dv_d    = 1'b1;
            phase_d = PH_ACK;
          end
          PH_ACK: if (!i_CM_Ready) phase_d = PH_CMPL;
          PH_CMPL: if (i_CM_Ready) begin
            phase_d = PH_ISSUE;
            case (state_q)
              S_WREN: state_d = S_LOAD;
              S_LOAD: state_d = S_EXEC;
              S_EXEC: begin
                state_d = S_POLL;
                seen_d  = 1'b0;
              end
              default: begin
                poll_cnt_d = poll_next;
                if (seen_d && !status_d[0]) begin
                  err_d   = status_d[3] ? 2'b01 : 2'b00;
                  state_d = S_DONE;
                end else if (poll_next == POLL_LIMIT) begin
                  err_d   = 2'b10;
                  state_d = S_DONE;
                end else begin
                  gap_cnt_d = '0;
                  state_d   = S_GAP;
                end
              end
            endcase
          end
          default: phase_d = PH_ISSUE;
        endcase
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_POLL;
          phase_d = PH_ISSUE;
          seen_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_ISSUE;
      row_q      <= '0;
      col_q      <= '0;
      bcnt_q     <= '0;
      fill_cnt_q <= '0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      seen_q     <= 1'b0;
      cmd_q      <= WRITE_ENABLE;
      addr_q     <= '0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      row_q      <= row_d;
      col_q      <= col_d;
      bcnt_q     <= bcnt_d;
      fill_cnt_q <= fill_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      seen_q     <= seen_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      dv_q       <= dv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      status_q   <= status_d;
    end
  end

  assign o_Command   = cmd_q;
  assign o_CM_DV     = dv_q;
  assign o_Addr_Data = addr_q;
  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_Error     = err_q;
  assign o_Status    = status_q;

endmodule

// File: tb/tb_nand_prog_sequencer.sv
// Bench for nand_prog_sequencer: a controller model answers each command
// with ready low for 5 cycles; a monitor checks every DV and done pulse
// against scoreboard queues filled when each request is started.
`timescale 1ns/1ps
module tb_nand_prog_sequencer;
  import nand_cmd_pkg::*;

  localparam int unsigned T_MAX_POLLS = 4;
  localparam int unsigned T_POLL_GAP  = 16;
  localparam int unsigned T_FILL_TO   = 100;
  // DV cycle -> 5 ready-low cycles + ready-rise cycle + POLL_GAP + ISSUE cycle
  localparam int GF_SPACING = T_POLL_GAP + 7;

  logic        CLK1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_Start = 1'b0;
  logic [23:0] i_Row_Addr = '0;
  logic [12:0] i_Col_Addr = '0;
  logic [11:0] i_Byte_Count = '0;
  logic [11:0] i_Fifo_Count = '0;
  SPI_Command  o_Command;
  logic        o_CM_DV;
  logic [23:0] o_Addr_Data;
  logic        i_CM_Ready;
  logic [7:0]  i_RX_Feature_Byte;
  logic        i_RX_Feature_DV;
  logic        o_Busy, o_Done;
  logic [1:0]  o_Error;
  logic [7:0]  o_Status;

  always #5 CLK1 = ~CLK1;

  nand_prog_sequencer #(
    .MAX_POLLS(T_MAX_POLLS), .POLL_GAP(T_POLL_GAP), .FILL_TIMEOUT(T_FILL_TO)
  ) dut (
    .CLK1(CLK1), .rst_n(rst_n), .i_Start(i_Start),
    .i_Row_Addr(i_Row_Addr), .i_Col_Addr(i_Col_Addr),
    .i_Byte_Count(i_Byte_Count), .i_Fifo_Count(i_Fifo_Count),
    .o_Command(o_Command), .o_CM_DV(o_CM_DV), .o_Addr_Data(o_Addr_Data),
    .i_CM_Ready(i_CM_Ready), .i_RX_Feature_Byte(i_RX_Feature_Byte),
    .i_RX_Feature_DV(i_RX_Feature_DV), .o_Busy(o_Busy), .o_Done(o_Done),
    .o_Error(o_Error), .o_Status(o_Status)
  );

  typedef struct { SPI_Command cmd; logic [23:0] addr; } dv_exp_t;

  int checks = 0;
  int errors = 0;
  dv_exp_t    dv_q[$];
  logic [9:0] done_q[$];      // {error, status}
  logic [7:0] stat_q[$];      // status bytes returned per poll
  logic [7:0] stat_default = 8'h00;
  int ack_hold = 0;           // extra ready-high cycles after GET_FEATURE DV
  int dv_count = 0;
  int done_count = 0;
  int cyc = 0;
  int last_gf = -1;
  int done_cyc = 0;
  SPI_Command model_cmd;

  always @(posedge CLK1) cyc <= cyc + 1;

  // Controller model.
  initial begin : ctrl_model
    i_CM_Ready = 1'b1;
    i_RX_Feature_DV = 1'b0;
    i_RX_Feature_Byte = 8'h00;
    forever begin
      @(negedge CLK1);
      if (o_CM_DV === 1'b1) begin
        model_cmd = o_Command;
        if (model_cmd == GET_FEATURE) repeat (ack_hold) @(negedge CLK1);
        #1 i_CM_Ready = 1'b0;
        repeat (4) @(negedge CLK1);
        if (model_cmd == GET_FEATURE) begin
          #1;
          i_RX_Feature_Byte = (stat_q.size() > 0) ? stat_q.pop_front() : stat_default;
          i_RX_Feature_DV = 1'b1;
          @(negedge CLK1);
          #1 i_RX_Feature_DV = 1'b0;
        end else begin
          @(negedge CLK1);
          #1;
        end
        i_CM_Ready = 1'b1;
      end
    end
  end

  // Output monitor / scoreboard consumer.
  initial begin : monitor
    logic prev_rdy;
    logic armed;
    dv_exp_t e;
    logic [9:0] d;
    prev_rdy = 1'b1;
    armed = 1'b1;
    forever begin
      @(negedge CLK1);
      if (!rst_n) begin
        armed = 1'b1;
        prev_rdy = i_CM_Ready;
      end else begin
        if (!prev_rdy && i_CM_Ready) armed = 1'b1;
        prev_rdy = i_CM_Ready;
        if (o_CM_DV) begin
          dv_count++;
          checks++;
          if (!armed) begin
            errors++;
            $display("FAIL dv_handshake: DV at cycle %0d with no ready low->high since previous DV", cyc);
          end
          armed = 1'b0;
          checks++;
          if (dv_q.size() == 0) begin
            errors++;
            $display("FAIL dv_unexpected: got %s addr %h, none required", o_Command.name(), o_Addr_Data);
          end else begin
            e = dv_q.pop_front();
            if (o_Command !== e.cmd || o_Addr_Data !== e.addr) begin
              errors++;
              $display("FAIL dv_order: got %s addr %h, required %s addr %h",
                       o_Command.name(), o_Addr_Data, e.cmd.name(), e.addr);
            end
          end
          if (o_Command == GET_FEATURE) begin
            if (last_gf >= 0) begin
              checks++;
              if (cyc - last_gf != GF_SPACING) begin
                errors++;
                $display("FAIL poll_spacing: got %0d cycles, required %0d", cyc - last_gf, GF_SPACING);
              end
            end
            last_gf = cyc;
          end
        end
        if (o_Done) begin
          done_count++;
          done_cyc = cyc;
          checks++;
          if (done_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: err %b status %h", o_Error, o_Status);
          end else begin
            d = done_q.pop_front();
            if ({o_Error, o_Status} !== d || o_Busy !== 1'b1) begin
              errors++;
              $display("FAIL done_result: got err %b status %h busy %b, required err %b status %h busy 1",
                       o_Error, o_Status, o_Busy, d[9:8], d[7:0]);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK1);
    #1;
  endtask

  task automatic push_prog(input logic [23:0] row, input logic [12:0] col, input int polls,
                           input logic [1:0] err, input logic [7:0] st);
    dv_q.push_back('{WRITE_ENABLE, 24'h000000});
    dv_q.push_back('{PROG_LOAD1, {11'd0, col}});
    dv_q.push_back('{PROG_EXEC, row});
    for (int i = 0; i < polls; i++) dv_q.push_back('{GET_FEATURE, 24'h00C000});
    done_q.push_back({err, st});
  endtask

  task automatic start_seq(input logic [23:0] row, input logic [12:0] col, input logic [11:0] bc);
    last_gf = -1;
    i_Row_Addr = row;
    i_Col_Addr = col;
    i_Byte_Count = bc;
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    for (int i = 0; i < budget && done_count < target; i++) tick();
    checks++;
    if (done_count < target) begin
      errors++;
      $display("FAIL %s_timeout: no o_Done within %0d cycles", name, budget);
    end else begin
      checks++;
      if (o_Busy !== 1'b0 || o_Done !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy_fall: got busy %b done %b, required 0 0", name, o_Busy, o_Done);
      end
      checks++;
      if (dv_q.size() != 0) begin
        errors++;
        $display("FAIL %s_missing_dv: %0d required DVs never issued", name, dv_q.size());
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (o_CM_DV !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b required 0", o_CM_DV); end
    checks++;
    if (o_Command !== WRITE_ENABLE) begin errors++; $display("FAIL reset_cmd: got %s required WRITE_ENABLE", o_Command.name()); end
    checks++;
    if (o_Addr_Data !== 24'h0) begin errors++; $display("FAIL reset_addr: got %h required 000000", o_Addr_Data); end
    checks++;
    if (o_Busy !== 1'b0 || o_Done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b %b required 0 0", o_Busy, o_Done); end
    checks++;
    if (o_Error !== 2'b00 || o_Status !== 8'h00) begin errors++; $display("FAIL reset_err_status: got %b %h required 00 00", o_Error, o_Status); end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    int base;
    base = done_count;
    i_Fifo_Count = 12'd128;
    stat_q.push_back(8'h00);
    push_prog(24'h000040, 13'h034, 1, 2'b00, 8'h00);
    start_seq(24'h000040, 13'h034, 12'd128);
    checks++;
    if (o_Busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b required 1", o_Busy); end
    wait_done(base + 1, 300, "basic");
  endtask

  task automatic test_program_fail();
    int base;
    base = done_count;
    stat_q = '{8'h01, 8'h01, 8'h01, 8'h08};
    push_prog(24'h012345, 13'h1ABC, 4, 2'b01, 8'h08);
    start_seq(24'h012345, 13'h1ABC, 12'd64);
    wait_done(base + 1, 400, "pfail");
  endtask

  task automatic test_poll_timeout();
    int base;
    base = done_count;
    stat_q.delete();
    stat_default = 8'h01;
    push_prog(24'hABCDEF, 13'h0001, T_MAX_POLLS, 2'b10, 8'h01);
    start_seq(24'hABCDEF, 13'h0001, 12'd1);
    wait_done(base + 1, 400, "poll_to");
    stat_default = 8'h00;
  endtask

  task automatic test_fill_timeout();
    int base, st;
    base = done_count;
    i_Fifo_Count = 12'd10;
    done_q.push_back({2'b11, 8'h00});
    start_seq(24'h000040, 13'h034, 12'd128);
    st = cyc;
    wait_done(base + 1, 300, "fill_to");
    checks++;
    if (done_cyc - st < int'(T_FILL_TO) || done_cyc - st > int'(T_FILL_TO) + 4) begin
      errors++;
      $display("FAIL fill_to_latency: got %0d cycles, required %0d..%0d", done_cyc - st, T_FILL_TO, T_FILL_TO + 4);
    end
    i_Fifo_Count = 12'd128;
  endtask

  task automatic test_zero_count();
    int base;
    base = done_count;
    i_Fifo_Count = 12'd0;
    push_prog(24'h000100, 13'h0000, 1, 2'b00, 8'h00);
    start_seq(24'h000100, 13'h0000, 12'd0);
    wait_done(base + 1, 300, "zero_cnt");
    i_Fifo_Count = 12'd128;
  endtask

  task automatic test_reset_mid();
    int base;
    base = dv_count;
    dv_q.push_back('{WRITE_ENABLE, 24'h000000});
    dv_q.push_back('{PROG_LOAD1, 24'h000034});
    dv_q.push_back('{PROG_EXEC, 24'h000040});
    start_seq(24'h000040, 13'h034, 12'd128);
    for (int i = 0; i < 200 && dv_count < base + 3; i++) tick();
    tick();
    tick();
    checks++;
    if (dv_count < base + 3) begin
      errors++;
      $display("FAIL rmid_reach_exec: got %0d DVs, required 3", dv_count - base);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_CM_DV, o_Command, o_Addr_Data, o_Busy, o_Done, o_Error, o_Status} !==
        {1'b0, WRITE_ENABLE, 24'h0, 1'b0, 1'b0, 2'b00, 8'h00}) begin
      errors++;
      $display("FAIL rmid_reset_values: got dv %b cmd %s addr %h busy %b done %b err %b st %h, required reset values",
               o_CM_DV, o_Command.name(), o_Addr_Data, o_Busy, o_Done, o_Error, o_Status);
    end
    repeat (3) tick();
    dv_q.delete();
    done_q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 50 && !i_CM_Ready; i++) tick();
    tick();
    base = done_count;
    stat_q = '{8'h00};
    push_prog(24'h000040, 13'h034, 1, 2'b00, 8'h00);
    start_seq(24'h000040, 13'h034, 12'd128);
    wait_done(base + 1, 300, "rmid_second");
  endtask

  task automatic test_start_ignored();
    int base, dbase;
    base = dv_count;
    dbase = done_count;
    ack_hold = 20;
    stat_q = '{8'h00};
    push_prog(24'h000777, 13'h0055, 1, 2'b00, 8'h00);
    start_seq(24'h000777, 13'h0055, 12'd16);
    for (int i = 0; i < 200 && dv_count < base + 4; i++) tick();
    repeat (3) tick();
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    checks++;
    if (o_Busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b required 1", o_Busy); end
    wait_done(dbase + 1, 300, "ign");
    repeat (40) tick();
    checks++;
    if (o_Busy !== 1'b0 || done_count != dbase + 1) begin
      errors++;
      $display("FAIL ign_no_restart: got busy %b done pulses %0d, required 0 and 1", o_Busy, done_count - dbase);
    end
    ack_hold = 0;
  endtask

  initial begin : main
    test_reset();
    test_basic();
    test_program_fail();
    test_poll_timeout();
    test_fill_timeout();
    test_zero_count();
    test_reset_mid();
    test_start_ignored();
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nand_prog_sequencer.md
# nand_prog_sequencer

Command sequencer that sits directly upstream of the SPI NAND memory command controller (`mem_command`) and turns one "program page" request into the full flash command chain: WRITE_ENABLE, PROG_LOAD1, PROG_EXEC, then repeated GET_FEATURE polling of status register C0h until the operation completes. It also waits for the controller's save FIFO to hold the requested byte count before loading, and reports pass/fail plus the final status byte. It replaces the hand-written test state machine in `top`.

## Interface
- MAX_POLLS, 1000: max GET_FEATURE polls before timeout error.
- POLL_GAP, 16: idle CLK1 cycles between polls.
- FILL_TIMEOUT, 65535: max cycles waiting in FILL; 16-bit counter.
- CLK1  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- i_Start  input  1  one-cycle request; sampled only in IDLE.
- i_Row_Addr  input  24  page/block row address for PROG_EXEC.
- i_Col_Addr  input  13  column address for PROG_LOAD1.
- i_Byte_Count  input  12  bytes the save FIFO must hold before loading.
- i_Fifo_Count  input  12  `o_fifo_save_count` from `mem_command`.
- o_Command  output  SPI_Command  command to `mem_command`; enumerators from command_vars.v.
- o_CM_DV  output  1  one-cycle command-valid pulse.
- o_Addr_Data  output  24  address/data word for `mem_command`.
- i_CM_Ready  input  1  controller ready.
- i_RX_Feature_Byte  input  8  feature byte returned by controller.
- i_RX_Feature_DV  input  1  feature byte valid pulse.
- o_Busy  output  1  high from accepted start until DONE exits.
- o_Done  output  1  one-cycle completion pulse.
- o_Error  output  2  00 ok, 01 program fail (P_FAIL), 10 poll timeout, 11 fill timeout.
- o_Status  output  8  last status byte captured.

## Operation
- States: IDLE, FILL, WREN, LOAD, EXEC, POLL, GAP, DONE. Each command state has phases ISSUE -> ACK -> CMPL.
- IDLE: on i_Start, latch row, column and byte count; clear o_Error and o_Status; go to FILL.
- FILL: if i_Fifo_Count >= latched count, go to WREN. i_Byte_Count = 0 passes immediately. If the counter reaches FILL_TIMEOUT, set o_Error=11 and go to DONE.
- ISSUE: wait for i_CM_Ready=1, then drive o_Command/o_Addr_Data, pulse o_CM_DV and enter ACK.
- ACK: wait for i_CM_Ready=0.
- CMPL: wait for i_CM_Ready=1, then advance.
- Address mapping:
  - WREN: WRITE_ENABLE, o_Addr_Data=0.
  - LOAD: PROG_LOAD1, [12:0]=column, upper bits 0.
  - EXEC: PROG_EXEC, [23:0]=row.
  - POLL: GET_FEATURE, [15:8]=C0h, rest 0.
- POLL: capture i_RX_Feature_Byte into o_Status on any i_RX_Feature_DV between ISSUE and CMPL. At CMPL, increment the poll counter, then:
  - If DV seen and bit0 (OIP)=0: set o_Error=01 if bit3 (P_FAIL)=1, else 00; go to DONE.
  - Otherwise (OIP=1 or no DV seen): if poll count = MAX_POLLS, set o_Error=10 and go to DONE; else go to GAP.
- GAP: count POLL_GAP cycles, then return to POLL.
- DONE: pulse o_Done for one cycle, go to IDLE. o_Error and o_Status hold until the next accepted start.
- i_Start outside IDLE is ignored.

## Timing
- Reset values: state IDLE, o_CM_DV=0, o_Command=WRITE_ENABLE, o_Addr_Data=0, o_Busy=0, o_Done=0, o_Error=00, o_Status=00h; all counters 0.
- Reset mid-operation aborts immediately with no partial pulse. `mem_command` shares rst_n.
- o_Busy rises the cycle after i_Start is sampled and falls the cycle after the o_Done pulse.
- o_CM_DV is high exactly one cycle per command. o_Command and o_Addr_Data become valid in the same cycle as DV and hold until the next ISSUE.
- No two DV pulses without an intervening i_CM_Ready low->high transition.
- Ready already high in ISSUE: DV issues the next cycle.
- i_RX_Feature_DV in the same cycle as the CMPL ready rise counts as seen.
- Minimum sequence with ready instant and one poll: start -> done in about 14 cycles plus FILL time.

## Test plan
- Model controller (ready drops for 5 cycles per command), FIFO count 128, byte count 128, col 034h, row 000040h, status 00h on first poll -> DV order WREN, LOAD(o_Addr_Data=000034h), EXEC(000040h), GET_FEATURE(00C000h); o_Done with o_Error=00, o_Status=00h.
- Status 01h for 3 polls, then 08h -> 4 GET_FEATURE pulses spaced at least POLL_GAP apart; o_Error=01, o_Status=08h.
- Status fixed at 01h, MAX_POLLS=4 -> exactly 4 polls, o_Error=10.
- FIFO count stuck at 10, byte count 128, FILL_TIMEOUT=100 -> no DV issued; o_Error=11 about 100 cycles after start.
- rst_n low during EXEC ACK, then i_Start again -> all outputs at reset values, second sequence completes normally with o_Error=00.
- i_Start pulsed during POLL and i_CM_Ready held high through ACK for 20 cycles -> no extra sequence and no second DV until ready drops and rises.
